wb_seg7_scan: RTL and testbench
===============================

WB_SEG7_SCAN -- requirements
Module: wb_seg7_scan

Interface
REQ-001 SHALL have parameter DIV_RST, default 16'd5000, meaning the reset value of SCAN_DIV in clocks per digit (1 kHz per digit at 5 MHz).
REQ-002 SHALL have port wb_clk_i, input, 1: the single system clock; all state is on its rising edge.
REQ-003 SHALL have port wb_rstn_i, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port wb_cyc_i, input, 1: Wishbone cycle.
REQ-005 SHALL have port wb_stb_i, input, 1: Wishbone strobe.
REQ-006 SHALL have port wb_we_i, input, 1: write enable.
REQ-007 SHALL have port wb_adr_i, input, 32: byte address; only [3:2] is decoded.
REQ-008 SHALL have port wb_dat_i, input, 32: write data.
REQ-009 SHALL have port wb_sel_i, input, 4: byte lane enables.
REQ-010 SHALL have port wb_dat_o, output, 32: read data.
REQ-011 SHALL have port wb_ack_o, output, 1: transfer acknowledge.
REQ-012 SHALL have port num_csn, output, 8: digit selects, active-low; bit n is digit n.
REQ-013 SHALL have port num_a_g, output, 7: segments, active-low; bit6=a down to bit0=g.

Function
REQ-014 SHALL decode the register map: adr[3:2]=0 is DATA[31:0] (nibble n shown on digit n), 1 is CTRL (bits[7:0] digit enable mask, bit8 blank-all, rest read 0), 2 is SCAN_DIV[15:0] (upper bits read 0), 3 is unmapped.
REQ-015 SHALL assert wb_ack_o exactly one cycle after the first cycle with cyc&stb high, for one cycle; ack SHALL be computed as cyc&stb&~ack, so a held strobe yields an ack on every second cycle.
REQ-016 SHALL perform a write on the ack cycle, updating only the byte lanes whose wb_sel_i bit is set.
REQ-017 SHALL ignore writes to adr 3; reads of adr 3 SHALL return 0, and all unmapped accesses SHALL still be acked.
REQ-018 SHALL register wb_dat_o and make it valid in the ack cycle; wb_dat_o SHALL be 0 outside ack cycles.
REQ-019 SHALL run a 16-bit scan counter that increments every clock; when it equals max(SCAN_DIV,1)-1 it SHALL return to 0 and the 3-bit digit index SHALL advance, wrapping from 7 to 0.
REQ-020 SHALL treat SCAN_DIV=0 and SCAN_DIV=1 identically: the index advances every clock.
REQ-021 SHALL clear the scan counter to 0, without changing the index, in the cycle after any write that touches SCAN_DIV.
REQ-022 SHALL register num_csn and num_a_g, which follow the index and register state with one cycle of latency.
REQ-023 SHALL drive num_csn as the active-low one-hot of the index when CTRL[index]=1 and CTRL[8]=0, and 8'hFF otherwise.
REQ-024 SHALL drive num_a_g as the hex glyph of DATA nibble[index] when the digit is lit, and 7'h7F otherwise.
REQ-025 SHALL use these glyphs: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-026 SHALL let a DATA or CTRL write in the same cycle as an index advance take effect on display outputs from the next cycle; no glitch cycle combining the old index with the new data SHALL be required or forbidden.

Reset
REQ-027 SHALL, while wb_rstn_i=0 and regardless of the clock, force DATA=0, CTRL=0x0FF, SCAN_DIV=DIV_RST, counter=0, index=0, wb_ack_o=0, wb_dat_o=0, num_csn=8'hFF and num_a_g=7'h7F.
REQ-028 SHALL abandon any in-flight transfer when reset asserts mid-transfer, with no ack issued for it; the first display update SHALL occur one cycle after reset release (digit 0, glyph 0).

Verification
REQ-029 SHALL be verified by: reset then release with DIV_RST=4 -> num_csn=FE, num_a_g=0000001 for 4 cycles, then FD, ..., 7F, then back to FE after 32 cycles.
REQ-030 SHALL be verified by: write DATA=0x89ABCDEF with sel=1111 -> digit0 shows F (0111000) and digit7 shows 8 (0000000); readback returns 0x89ABCDEF.
REQ-031 SHALL be verified by: write CTRL=0x00000105 -> all digits blank (num_csn=FF); then write CTRL=0x05 -> only digits 0 and 2 go low.
REQ-032 SHALL be verified by: write SCAN_DIV=0 -> index advances every clock, num_csn cycles FE,FD,FB,... on consecutive cycles.
REQ-033 SHALL be verified by: a byte write sel=0010 with data 0x0000AB00 to DATA=0x11111111 -> readback 0x1111AB11; a read of adr 0xC returns 0 with ack.
REQ-034 SHALL be verified by: holding stb high for 6 cycles -> acks at cycles 2, 4 and 6 only; reset asserted while stb is high -> no ack and outputs at reset values.

Source files
------------

// File: rtl/wb_seg7_scan.sv
// Wishbone-controlled scanner for an 8-digit multiplexed 7-segment hex display.
// Registers: DATA (one nibble per digit), CTRL (digit mask + blank), SCAN_DIV (clocks per digit).
module wb_seg7_scan #(
  parameter logic [15:0] DIV_RST = 16'd5000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rstn_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [7:0]  num_csn,
  output logic [6:0]  num_a_g
);

  localparam logic [1:0] ADR_DATA = 2'd0;
  localparam logic [1:0] ADR_CTRL = 2'd1;
  localparam logic [1:0] ADR_DIV  = 2'd2;

  // Bus handshake: wb_cyc_i & wb_stb_i is the request; wb_ack_o answers one cycle
  // later for exactly one cycle. A held strobe is treated as back-to-back requests,
  // so ack toggles every second cycle. Writes land on the edge that raises ack.

  logic [31:0] data_q;
  logic [8:0]  ctrl_q;
  logic [15:0] div_q;
  logic [15:0] cnt_q;
  logic [2:0]  idx_q;

  logic        req;
  logic        wr_en;
  logic [1:0]  reg_sel;
  logic        div_touch;
  logic [31:0] data_wr;
  logic [8:0]  ctrl_wr;
  logic [15:0] div_wr;
  logic [31:0] rd_data;
  logic [15:0] scan_max;
  logic        lit;
  logic [3:0]  nib;
  logic [6:0]  glyph;
  logic        unused_adr;

  assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_en     = req & wb_we_i;
  assign reg_sel   = wb_adr_i[3:2];
  assign div_touch = wr_en & (reg_sel == ADR_DIV) & (|wb_sel_i[1:0]);
  assign unused_adr = &{1'b0, wb_adr_i[31:4], wb_adr_i[1:0]};

  // Byte-lane merge of write data into each register.
  always_comb begin
    data_wr = data_q;
    for (int b = 0; b < 4; b++) begin
      if (wb_sel_i[b]) data_wr[8*b +: 8] = wb_dat_i[8*b +: 8];
    end
    ctrl_wr = {(wb_sel_i[1] ? wb_dat_i[8] : ctrl_q[8]),
               (wb_sel_i[0] ? wb_dat_i[7:0] : ctrl_q[7:0])};
    div_wr  = {(wb_sel_i[1] ? wb_dat_i[15:8] : div_q[15:8]),
               (wb_sel_i[0] ? wb_dat_i[7:0] : div_q[7:0])};
  end

  always_comb begin
    rd_data = 32'd0;
    case (reg_sel)
      ADR_DATA: rd_data = data_q;
      ADR_CTRL: rd_data = {23'd0, ctrl_q};
      ADR_DIV:  rd_data = {16'd0, div_q};
      default:  rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'd0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= (req & ~wb_we_i) ? rd_data : 32'd0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      data_q <= 32'd0;
      ctrl_q <= 9'h0FF;
      div_q  <= DIV_RST;
    end else if (wr_en) begin
      case (reg_sel)
        ADR_DATA: data_q <= data_wr;
        ADR_CTRL: ctrl_q <= ctrl_wr;
        ADR_DIV:  div_q  <= div_wr;
        default:  ;
      endcase
    end
  end

  // Divider values 0 and 1 both mean "advance every clock".
  assign scan_max = (div_q <= 16'd1) ? 16'd0 : (div_q - 16'd1);

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      cnt_q <= 16'd0;
      idx_q <= 3'd0;
    end else if (div_touch) begin
      cnt_q <= 16'd0;
    end else if (cnt_q == scan_max) begin
      cnt_q <= 16'd0;
      idx_q <= idx_q + 3'd1;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign lit = ctrl_q[idx_q] & ~ctrl_q[8];
  assign nib = data_q[{idx_q, 2'b00} +: 4];

  // Active-low segments, bit6 = a ... bit0 = g.
  always_comb begin
    glyph = 7'h7F;
    case (nib)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      num_csn <= 8'hFF;
      num_a_g <= 7'h7F;
    end else begin
      num_csn <= lit ? ~(8'd1 << idx_q) : 8'hFF;
      num_a_g <= lit ? glyph : 7'h7F;
    end
  end

endmodule

// File: tb/tb_wb_seg7_scan.sv
// Directed bench for wb_seg7_scan: register table, scan timing, masking, ack pacing, reset.
module tb_wb_seg7_scan;

  logic        wb_clk_i;
  logic        wb_rstn_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [7:0]  num_csn;
  logic [6:0]  num_a_g;

  int checks;
  int failures;

  wb_seg7_scan #(.DIV_RST(16'd4)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rstn_i(wb_rstn_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .num_csn  (num_csn),
    .num_a_g  (num_a_g)
  );

  // clock / reset
  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [20];

  function automatic logic [6:0] ref_glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b0000001;  4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;  4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;  4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;  4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;  4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;  4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;  4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;  default: g = 7'b0111000;
    endcase
    return g;
  endfunction

  function automatic logic [7:0] csn_of(input int i);
    logic [7:0] one;
    one = 8'd1 << i;
    return ~one;
  endfunction

  function automatic logic [3:0] nib_of(input logic [31:0] d, input int i);
    logic [31:0] t;
    t = d >> (4 * i);
    return t[3:0];
  endfunction

  function automatic int idx_of(input logic [7:0] csn);
    int r;
    r = -1;
    for (int j = 0; j < 8; j++) if (csn == csn_of(j)) r = j;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: one single-beat transfer starting on a falling edge
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
    @(negedge wb_clk_i);
    chk("ack_latency", {31'd0, wb_ack_o}, 32'd1);
    rd = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge wb_clk_i);
    chk("ack_single", {31'd0, wb_ack_o}, 32'd0);
    chk("dat_idle_zero", wb_dat_o, 32'd0);
  endtask

  // with SCAN_DIV=0 and all digits enabled the index steps once per clock
  task automatic scan_walk(input int n, input logic [31:0] data);
    int start;
    int e;
    @(negedge wb_clk_i);
    start = idx_of(num_csn);
    chk("scan_onehot", {31'd0, (start >= 0)}, 32'd1);
    if (start < 0) start = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge wb_clk_i);
      e = (start + i) % 8;
      chk("scan_csn", {24'd0, num_csn}, {24'd0, csn_of(e)});
      chk("scan_glyph", {25'd0, num_a_g}, {25'd0, ref_glyph(nib_of(data, e))});
    end
  endtask

  logic [31:0] rd;
  logic [31:0] data_v;
  int          idx_i;
  int          n_fe;
  int          n_fb;
  logic        ok;
  logic [5:0]  ack_seen;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    wb_rstn_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = 32'd0; wb_dat_i = 32'd0; wb_sel_i = 4'h0;

    vecs[0]  = '{1'b0, 32'h0, 32'h0,        4'hF, 32'h0};
    vecs[1]  = '{1'b0, 32'h4, 32'h0,        4'hF, 32'h0FF};
    vecs[2]  = '{1'b0, 32'h8, 32'h0,        4'hF, 32'h4};
    vecs[3]  = '{1'b0, 32'hC, 32'h0,        4'hF, 32'h0};
    vecs[4]  = '{1'b1, 32'h0, 32'h11111111, 4'hF, 32'h0};
    vecs[5]  = '{1'b1, 32'h0, 32'h0000AB00, 4'h2, 32'h0};
    vecs[6]  = '{1'b0, 32'h0, 32'h0,        4'hF, 32'h1111AB11};
    vecs[7]  = '{1'b1, 32'hC, 32'hDEADBEEF, 4'hF, 32'h0};
    vecs[8]  = '{1'b0, 32'hC, 32'h0,        4'hF, 32'h0};
    vecs[9]  = '{1'b0, 32'h0, 32'h0,        4'hF, 32'h1111AB11};
    vecs[10] = '{1'b1, 32'h4, 32'hFFFFFFFF, 4'hF, 32'h0};
    vecs[11] = '{1'b0, 32'h4, 32'h0,        4'hF, 32'h1FF};
    vecs[12] = '{1'b1, 32'h4, 32'h00000000, 4'h2, 32'h0};
    vecs[13] = '{1'b0, 32'h4, 32'h0,        4'hF, 32'h0FF};
    vecs[14] = '{1'b1, 32'h8, 32'hFFFF1234, 4'h1, 32'h0};
    vecs[15] = '{1'b0, 32'h8, 32'h0,        4'hF, 32'h0034};
    vecs[16] = '{1'b1, 32'h8, 32'hFFFF0004, 4'hF, 32'h0};
    vecs[17] = '{1'b0, 32'h8, 32'h0,        4'hF, 32'h4};
    vecs[18] = '{1'b1, 32'h0, 32'h89ABCDEF, 4'hF, 32'h0};
    vecs[19] = '{1'b0, 32'h0, 32'h0,        4'hF, 32'h89ABCDEF};

    // reset state
    repeat (2) @(negedge wb_clk_i);
    chk("rst_csn", {24'd0, num_csn}, 32'hFF);
    chk("rst_a_g", {25'd0, num_a_g}, 32'h7F);
    chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);

    // scan timing with DIV_RST=4: four samples per digit, wraps after 32
    wb_rstn_i = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      @(negedge wb_clk_i);
      chk("div4_csn", {24'd0, num_csn}, {24'd0, csn_of(((k - 1) / 4) % 8)});
      chk("div4_a_g", {25'd0, num_a_g}, 32'b0000001);
    end

    // register table
    for (int v = 0; v < 20; v++) begin
      wb_xfer(vecs[v].we, vecs[v].adr, vecs[v].dat, vecs[v].sel, rd);
      if (!vecs[v].we) chk($sformatf("reg_rd_%0d", v), rd, vecs[v].exp);
    end

    // writing SCAN_DIV restarts the count without moving the index
    wb_xfer(1'b1, 32'h8, 32'h4, 4'hF, rd);
    idx_i = idx_of(num_csn);
    chk("divclr_onehot", {31'd0, (idx_i >= 0)}, 32'd1);
    if (idx_i < 0) idx_i = 0;
    for (int j = 2; j <= 4; j++) begin
      @(negedge wb_clk_i);
      chk("divclr_hold", {24'd0, num_csn}, {24'd0, csn_of(idx_i)});
    end
    @(negedge wb_clk_i);
    chk("divclr_step", {24'd0, num_csn}, {24'd0, csn_of((idx_i + 1) % 8)});

    // SCAN_DIV=0 advances every clock; glyphs follow DATA=89ABCDEF
    data_v = 32'h89ABCDEF;
    wb_xfer(1'b1, 32'h8, 32'h0, 4'hF, rd);
    scan_walk(16, data_v);

    // blank-all overrides the digit mask
    wb_xfer(1'b1, 32'h4, 32'h105, 4'hF, rd);
    for (int i = 0; i < 8; i++) begin
      @(negedge wb_clk_i);
      chk("blank_csn", {24'd0, num_csn}, 32'hFF);
      chk("blank_a_g", {25'd0, num_a_g}, 32'h7F);
    end

    // mask 0x05: only digits 0 and 2 light
    wb_xfer(1'b1, 32'h4, 32'h05, 4'hF, rd);
    n_fe = 0; n_fb = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge wb_clk_i);
      ok = (num_csn == 8'hFF) || (num_csn == 8'hFE) || (num_csn == 8'hFB);
      chk("mask_csn_allowed", {31'd0, ok}, 32'd1);
      if (num_csn == 8'hFE) begin
        n_fe++;
        chk("mask_d0_glyph", {25'd0, num_a_g}, {25'd0, ref_glyph(4'hF)});
      end else if (num_csn == 8'hFB) begin
        n_fb++;
        chk("mask_d2_glyph", {25'd0, num_a_g}, {25'd0, ref_glyph(4'hD)});
      end else begin
        chk("mask_off_a_g", {25'd0, num_a_g}, 32'h7F);
      end
    end
    chk("mask_d0_count", n_fe, 32'd1);
    chk("mask_d2_count", n_fb, 32'd1);
    wb_xfer(1'b1, 32'h4, 32'hFF, 4'hF, rd);

    // held strobe: acks on every second cycle
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0; wb_sel_i = 4'hF;
    for (int c = 0; c < 6; c++) begin
      @(negedge wb_clk_i);
      ack_seen[c] = wb_ack_o;
      if (c == 4) begin
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      end
    end
    chk("held_stb_acks", {26'd0, ack_seen}, 32'b010101);

    // reset in the middle of a transfer
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0;
    #2 wb_rstn_i = 1'b0;
    #1;
    chk("async_rst_csn", {24'd0, num_csn}, 32'hFF);
    chk("async_rst_a_g", {25'd0, num_a_g}, 32'h7F);
    for (int i = 0; i < 2; i++) begin
      @(negedge wb_clk_i);
      chk("midrst_ack", {31'd0, wb_ack_o}, 32'd0);
      chk("midrst_dat", wb_dat_o, 32'd0);
      chk("midrst_csn", {24'd0, num_csn}, 32'hFF);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    wb_rstn_i = 1'b1;
    @(negedge wb_clk_i);
    chk("post_rst_csn", {24'd0, num_csn}, 32'hFE);
    chk("post_rst_a_g", {25'd0, num_a_g}, 32'b0000001);
    chk("post_rst_ack", {31'd0, wb_ack_o}, 32'd0);
    wb_xfer(1'b0, 32'h0, 32'h0, 4'hF, rd);
    chk("post_rst_data", rd, 32'h0);
    wb_xfer(1'b0, 32'h8, 32'h0, 4'hF, rd);
    chk("post_rst_div", rd, 32'h4);
    wb_xfer(1'b0, 32'h4, 32'h0, 4'hF, rd);
    chk("post_rst_ctrl", rd, 32'h0FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
